// File: rtl/ram_block_mover.sv
// Block FILL / COPY engine that masters the single-port RAM while Busy is high.
// Define RAM_MOVER_CHECKSUM_EN to build the running sum of written words on Checksum.
module ram_block_mover #(
    parameter int ADDR_BITS  = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Op,
    input  logic [ADDR_BITS-1:0]  SrcAddr,
    input  logic [ADDR_BITS-1:0]  DstAddr,
    input  logic [ADDR_BITS:0]    Length,
    input  logic [DATA_WIDTH-1:0] FillValue,
    output logic                  Busy,
    output logic                  Done,
    output logic                  CS,
    output logic                  RW,
    output logic [15:0]           RAM_ADDR,
    output logic [DATA_WIDTH-1:0] RAM_WDATA,
    input  logic [DATA_WIDTH-1:0] RAM_RDATA,
    output logic [DATA_WIDTH-1:0] Checksum
);

    typedef enum logic [2:0] {IDLE, FILL, RD, WR, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  src_q, src_d;
    logic [ADDR_BITS-1:0]  dst_q, dst_d;
    logic [ADDR_BITS:0]    remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic                  cs_q, cs_d;
    logic                  rw_q, rw_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  last_word;

    assign last_word = (remaining_q == {{ADDR_BITS{1'b0}}, 1'b1});

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            remaining_q <= '0;
            fill_q      <= '0;
            cs_q        <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            remaining_q <= remaining_d;
            fill_q      <= fill_d;
            cs_q        <= cs_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Bus signals are computed one cycle ahead so each RAM cycle comes straight from flops.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        remaining_d = remaining_q;
        fill_d      = fill_q;
        cs_d        = 1'b0;
        rw_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    src_d       = SrcAddr;
                    dst_d       = DstAddr;
                    remaining_d = Length;
                    fill_d      = FillValue;
                    if (Length == '0) begin
                        state_d = DONE;
                    end else if (!Op) begin
                        state_d = FILL;
                        cs_d    = 1'b1;
                        rw_d    = 1'b1;
                        addr_d  = DstAddr;
                        wdata_d = FillValue;
                    end else begin
                        state_d = RD;
                        cs_d    = 1'b1;
                        rw_d    = 1'b0;
                        addr_d  = SrcAddr;
                    end
                end
            end
            FILL: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    dst_d       = dst_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    cs_d        = 1'b1;
                    rw_d        = 1'b1;
                    addr_d      = dst_q + 1'b1;
                    wdata_d     = fill_q;
                end
            end
            RD: begin
                state_d = WR;
                cs_d    = 1'b1;
                rw_d    = 1'b1;
                addr_d  = dst_q;
            end
            WR: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    state_d     = RD;
                    src_d       = src_q + 1'b1;
                    dst_d       = dst_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    cs_d        = 1'b1;
                    rw_d        = 1'b0;
                    addr_d      = src_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Busy     = (state_q == FILL) || (state_q == RD) || (state_q == WR);
    assign Done     = (state_q == DONE);
    assign CS       = cs_q;
    assign RW       = rw_q;
    assign RAM_ADDR = 16'(addr_q);
    // The RAM holds its read data for the whole WR cycle, so copy data bypasses the flops.
    assign RAM_WDATA = (state_q == WR) ? RAM_RDATA : wdata_q;

`ifdef RAM_MOVER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            checksum_q <= '0;
        end else if (state_q == IDLE && Start) begin
            checksum_q <= '0;
        end else if (cs_q && rw_q) begin
            checksum_q <= checksum_q + RAM_WDATA;
        end
    end

    assign Checksum = checksum_q;
`else
    assign Checksum = '0;
`endif

endmodule

// File: tb/tb_ram_block_mover.sv
// Scoreboard bench for ram_block_mover: expected bus cycles and Done pulses are queued by
// the stimulus and consumed by a negedge monitor attached to a behavioural RAM.
module tb_ram_block_mover;

    localparam int AW = 12;
    localparam int DW = 16;
`ifdef RAM_MOVER_CHECKSUM_EN
    localparam logic [DW-1:0] CK_MASK = 16'hFFFF;
`else
    localparam logic [DW-1:0] CK_MASK = 16'h0000;
`endif

    typedef struct {
        bit          is_done;
        bit          rw;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] ck;
    } exp_t;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic          Op = 1'b0;
    logic [AW-1:0] SrcAddr = '0;
    logic [AW-1:0] DstAddr = '0;
    logic [AW:0]   Length = '0;
    logic [DW-1:0] FillValue = '0;
    logic          Busy, Done, CS, RW;
    logic [15:0]   RAM_ADDR;
    logic [DW-1:0] RAM_WDATA;
    logic [DW-1:0] RAM_RDATA = '0;
    logic [DW-1:0] Checksum;

    logic [DW-1:0] mem [0:4095] = '{default: '0};
    logic          poke_we = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [DW-1:0] poke_data = '0;

    exp_t sb[$];
    exp_t mon_e;
    int   n_compared = 0;
    int   n_mismatched = 0;

    ram_block_mover #(.ADDR_BITS(AW), .DATA_WIDTH(DW)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
        .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length), .FillValue(FillValue),
        .Busy(Busy), .Done(Done), .CS(CS), .RW(RW), .RAM_ADDR(RAM_ADDR),
        .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA), .Checksum(Checksum)
    );

    always #5 Clock = ~Clock;

    // Single-port RAM with a one-cycle registered read; poke port preloads while idle.
    always @(posedge Clock) begin
        if (CS && RW) mem[RAM_ADDR[AW-1:0]] <= RAM_WDATA;
        else if (poke_we) mem[poke_addr] <= poke_data;
        if (CS && !RW) RAM_RDATA <= mem[RAM_ADDR[AW-1:0]];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic exp_bus(input bit rw, input logic [15:0] addr, input logic [15:0] data);
        exp_t e;
        e.is_done = 1'b0; e.rw = rw; e.addr = addr; e.data = data; e.ck = '0;
        sb.push_back(e);
    endtask

    task automatic exp_done(input logic [15:0] ck);
        exp_t e;
        e.is_done = 1'b1; e.rw = 1'b0; e.addr = '0; e.data = '0; e.ck = ck & CK_MASK;
        sb.push_back(e);
    endtask

    task automatic ram_poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        poke_we = 1'b1; poke_addr = a; poke_data = d;
        @(posedge Clock); #1;
        poke_we = 1'b0;
    endtask

    // Returns 1 ns after edge T, the edge that samples Start.
    task automatic applyStimulus(input bit op, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                                 input logic [AW:0] len, input logic [DW-1:0] fill);
        @(posedge Clock); #1;
        Start = 1'b1; Op = op; SrcAddr = src; DstAddr = dst; Length = len; FillValue = fill;
        @(posedge Clock); #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(input int want_cycles, input string name);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge Clock);
            n++;
            if (Done) seen = 1'b1;
        end
        if (!seen) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL %s_timeout: got no Done in %0d cycles, want Done", name, n);
        end else begin
            checkOutput({name, "_latency"}, n, want_cycles);
        end
        @(posedge Clock); #1;
    endtask

    always @(negedge Clock) begin
        if (!Reset) begin
            if (CS) begin
                if (sb.size() == 0 || sb[0].is_done) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_bus: got addr 0x%0h rw %0b, want no RAM cycle", RAM_ADDR, RW);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("bus_rw", RW, mon_e.rw);
                    checkOutput("bus_addr", RAM_ADDR, mon_e.addr);
                    if (mon_e.rw) checkOutput("bus_wdata", RAM_WDATA, mon_e.data);
                end
            end
            if (Done) begin
                if (sb.size() == 0 || !sb[0].is_done) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_done: got Done=1, want pending queue entry (depth %0d)", sb.size());
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("done_checksum", Checksum, mon_e.ck);
                    checkOutput("done_busy", Busy, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, want finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        repeat (2) @(posedge Clock);
        #1;
        checkOutput("rst_busy", Busy, 0);
        checkOutput("rst_done", Done, 0);
        checkOutput("rst_cs", CS, 0);
        checkOutput("rst_rw", RW, 0);
        checkOutput("rst_addr", RAM_ADDR, 0);
        checkOutput("rst_wdata", RAM_WDATA, 0);
        checkOutput("rst_checksum", Checksum, 0);
        Reset = 1'b0;

        $display("[TB] fill 4 words at 0x010");
        for (int i = 0; i < 4; i++) exp_bus(1'b1, 16'h0010 + 16'(i), 16'h1234);
        exp_done(16'h48D0);
        applyStimulus(1'b0, 12'h000, 12'h010, 13'd4, 16'h1234);
        checkOutput("fill_busy", Busy, 1);
        wait_done(5, "fill");
        checkOutput("fill_sb_drained", sb.size(), 0);

        $display("[TB] copy 3 words 0x020 -> 0x200");
        ram_poke(12'h020, 16'h0001);
        ram_poke(12'h021, 16'h0002);
        ram_poke(12'h022, 16'h0003);
        for (int i = 0; i < 3; i++) begin
            exp_bus(1'b0, 16'h0020 + 16'(i), 16'h0000);
            exp_bus(1'b1, 16'h0200 + 16'(i), 16'(i + 1));
        end
        exp_done(16'h0006);
        applyStimulus(1'b1, 12'h020, 12'h200, 13'd3, 16'h0000);
        checkOutput("copy_busy", Busy, 1);
        wait_done(7, "copy");
        checkOutput("copy_mem200", mem[12'h200], 16'h0001);
        checkOutput("copy_mem201", mem[12'h201], 16'h0002);
        checkOutput("copy_mem202", mem[12'h202], 16'h0003);

        $display("[TB] fill wrapping past the top of RAM");
        exp_bus(1'b1, 16'h0FFE, 16'h0F0F);
        exp_bus(1'b1, 16'h0FFF, 16'h0F0F);
        exp_bus(1'b1, 16'h0000, 16'h0F0F);
        exp_bus(1'b1, 16'h0001, 16'h0F0F);
        exp_done(16'h3C3C);
        applyStimulus(1'b0, 12'h000, 12'hFFE, 13'd4, 16'h0F0F);
        wait_done(5, "wrap");

        $display("[TB] zero-length command");
        exp_done(16'h0000);
        applyStimulus(1'b0, 12'h000, 12'h080, 13'd0, 16'hFFFF);
        checkOutput("len0_busy", Busy, 0);
        wait_done(1, "len0");

        $display("[TB] start pulsed while busy");
        for (int i = 0; i < 4; i++) exp_bus(1'b1, 16'h0040 + 16'(i), 16'h5555);
        exp_done(16'h5554);
        applyStimulus(1'b0, 12'h000, 12'h040, 13'd4, 16'h5555);
        Start = 1'b1; Op = 1'b0; DstAddr = 12'h050; Length = 13'd2; FillValue = 16'h7777;
        @(posedge Clock); #1;
        Start = 1'b0;
        wait_done(4, "busy_start");
        repeat (4) @(posedge Clock);
        #1;
        checkOutput("busy_start_sb_drained", sb.size(), 0);

        $display("[TB] overlapping copy 0x300 -> 0x301");
        ram_poke(12'h300, 16'hBEEF);
        for (int i = 0; i < 3; i++) begin
            exp_bus(1'b0, 16'h0300 + 16'(i), 16'h0000);
            exp_bus(1'b1, 16'h0301 + 16'(i), 16'hBEEF);
        end
        exp_done(16'h3CCD);
        applyStimulus(1'b1, 12'h300, 12'h301, 13'd3, 16'h0000);
        wait_done(7, "overlap");
        for (int i = 1; i <= 3; i++) checkOutput("overlap_mem", mem[12'h300 + 12'(i)], 16'hBEEF);

        $display("[TB] reset during fill");
        for (int i = 0; i < 3; i++) exp_bus(1'b1, 16'h0100 + 16'(i), 16'hAAAA);
        applyStimulus(1'b0, 12'h000, 12'h100, 13'd8, 16'hAAAA);
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b1;
        #1;
        checkOutput("midrst_cs", CS, 0);
        checkOutput("midrst_busy", Busy, 0);
        checkOutput("midrst_done", Done, 0);
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        checkOutput("midrst_sb_drained", sb.size(), 0);
        for (int i = 0; i < 3; i++) checkOutput("midrst_written", mem[12'h100 + 12'(i)], 16'hAAAA);
        for (int i = 3; i < 8; i++) checkOutput("midrst_untouched", mem[12'h100 + 12'(i)], 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/ram_block_mover.md
Name: ram_block_mover

Overview:
- Bus initiator for the 16-bit single-port RAM interface (CS / RW / RAM_ADDR / data in / data out, registered read with one-cycle latency).
- Performs block FILL (constant value into a range) and block COPY (range to range) on command from game logic.
- Used to clear the playfield and relocate sprite/score tables without CPU involvement.
- Sits between the game control FSM and the RAM; it is the sole RAM master while Busy is high.

Parameters:
- ADDR_BITS, 12, RAM word-address width; addresses wrap modulo 2**ADDR_BITS.
- DATA_WIDTH, 16, RAM word width.

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  command strobe, sampled only in IDLE
- Op  in  1  0 = FILL, 1 = COPY
- SrcAddr  in  ADDR_BITS  COPY source base
- DstAddr  in  ADDR_BITS  destination base (both ops)
- Length  in  ADDR_BITS+1  word count, 0..2**ADDR_BITS
- FillValue  in  DATA_WIDTH  FILL data
- Busy  out  1  high while a transfer is in progress
- Done  out  1  one-cycle completion pulse
- CS  out  1  RAM chip select
- RW  out  1  1 = write, 0 = read
- RAM_ADDR  out  16  RAM address; bits above ADDR_BITS driven 0
- RAM_WDATA  out  DATA_WIDTH  to RAM data input
- RAM_RDATA  in  DATA_WIDTH  from RAM registered data output
- Checksum  out  DATA_WIDTH  see Optional Feature

Behaviour:
- Reset (async): state IDLE; Busy = 0, Done = 0, CS = 0, RW = 0, RAM_ADDR = 0, RAM_WDATA = 0, Checksum = 0. Takes effect mid-transfer immediately; the transfer is abandoned and CS drops with no further RAM cycles.
- States: IDLE, FILL, RD, WR, DONE.
- IDLE: Start = 1 on edge T latches Op, Src, Dst, Length and FillValue into internal registers.
  - Length = 0 -> DONE.
  - Otherwise FILL if Op = 0, RD if Op = 1.
  - Start is ignored in every state other than IDLE.
- Busy = 1 exactly in FILL, RD and WR. Done = 1 exactly in DONE, for one cycle; the next state is IDLE.
- CS, RW, RAM_ADDR and RAM_WDATA (FILL mode) are registered; the first RAM cycle is presented in the cycle after edge T.
- FILL: one word per cycle.
  - CS = 1, RW = 1, RAM_ADDR = dst, RAM_WDATA = latched FillValue.
  - dst increments each cycle; the remaining count decrements.
  - Exits to DONE after the last word's cycle.
  - N words take N cycles; Done asserts in cycle N+1 after T.
- COPY: two cycles per word.
  - RD: CS = 1, RW = 0, RAM_ADDR = src.
  - WR: CS = 1, RW = 1, RAM_ADDR = dst, RAM_WDATA = RAM_RDATA, passed through combinationally (the RAM output is stable for the whole WR cycle).
  - src and dst increment after WR.
  - RD -> WR always; WR -> RD while words remain, else DONE.
  - N words take 2N cycles.
- Address arithmetic is modulo 2**ADDR_BITS; ranges crossing the top wrap to 0.
- Overlapping COPY ranges use forward (ascending) order with no overlap protection. Dst = Src + 1 therefore replicates the first word.
- Length = 2**ADDR_BITS is legal and covers the whole RAM.
- No RAM access (CS = 0) occurs in IDLE or DONE.

Optional Feature:
- Macro: RAM_MOVER_CHECKSUM_EN.
- Defined:
  - Checksum holds the modulo-2**DATA_WIDTH sum of every word written during the current command.
  - It is cleared when Start is accepted and updated on each write cycle.
  - It is final and stable from the Done cycle until the next accepted Start.
- Undefined: Checksum is tied to 0 and no adder is built; the port list is unchanged.

Test Plan:
- Reset mid-FILL: Start FILL Dst = 0x100, Len = 8, FillValue = 0xAAAA; assert Reset after 3 writes -> CS = 0 within the same cycle, Busy = 0, no Done; RAM 0x100..0x102 = 0xAAAA, 0x103..0x107 untouched.
- FILL: Dst = 0x010, Len = 4, FillValue = 0x1234 -> exactly 4 cycles with CS = 1, RW = 1 at addresses 0x010..0x013; Done pulse 1 cycle later; with CHECKSUM_EN, Checksum = 0x48D0.
- COPY: RAM 0x020..0x022 = 0x0001, 0x0002, 0x0003; Src = 0x020, Dst = 0x200, Len = 3 -> 6 RAM cycles alternating RW 0/1; RAM 0x200..0x202 = 0x0001..0x0003; Checksum = 0x0006.
- Wrap: FILL Dst = 0xFFE, Len = 4 -> writes at 0xFFE, 0xFFF, 0x000, 0x001; RAM_ADDR[15:12] = 0 throughout.
- Length = 0 and Start while busy: Start Len = 0 -> Done 1 cycle later with no CS; Start pulsed during a 4-word FILL -> ignored, exactly one Done.
- Overlap: RAM 0x300 = 0xBEEF; COPY Src = 0x300, Dst = 0x301, Len = 3 -> 0x301..0x303 = 0xBEEF.
